// File: rtl/fpcvt_arb.sv
`default_nettype none
// ============================================================================
//  Module      : fpcvt_arb
//  Description : Round-robin arbiter and sequencer sharing one combinational
//                12-bit two's-complement to small floating-point converter
//                (sign / 3-bit exponent / 4-bit significand) between N_REQ
//                requesters. Results are tagged with the requester index and
//                presented on a single valid/ready output port.
//  Revision    : 1.0 - initial release
// ============================================================================
module fpcvt_arb #(
    parameter int N_REQ = 4,   // number of requesters, 2..8
    parameter int ID_W  = 2    // must equal $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [12*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ID_W-1:0]       out_id,
    output logic                  out_s,
    output logic [2:0]            out_e,
    output logic [3:0]            out_f,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state;
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    gnt_q;
    logic [11:0]        din_q;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic               found_hi;
    logic [ID_W-1:0]    idx_hi;
    logic [ID_W-1:0]    idx_lo;
    logic               grant_found;
    logic [ID_W-1:0]    grant_idx;
    logic [11:0]        grant_data;

    // Round-robin search split into two priority passes: the lowest valid
    // index at or above ptr wins; if none, wrap to the lowest valid index.
    always_comb begin
        found_hi = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (ID_W'(i) >= ptr)) begin
                found_hi = 1'b1;
                idx_hi   = ID_W'(i);
            end
            if (req_valid[i]) begin
                idx_lo = ID_W'(i);
            end
        end
        grant_found = |req_valid;
        grant_idx   = found_hi ? idx_hi : idx_lo;
    end

    // Select the granted requester's sample for capture into din_q.
    always_comb begin
        grant_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                grant_data = req_data[i*12 +: 12];
            end
        end
    end

    // Ready is a one-hot of the grant, only while idle and out of reset.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = rst_n && (state == IDLE) && grant_found &&
                           (grant_idx == ID_W'(i));
        end
    end

    // ------------------------------------------------------------------
    // Shared converter (purely combinational from din_q)
    // ------------------------------------------------------------------
    logic [10:0]        mag;
    logic [2:0]         raw_e;
    logic [3:0]         raw_f;
    logic               rnd;
    logic [4:0]         sum;
    logic               conv_s;
    logic [2:0]         conv_e;
    logic [3:0]         conv_f;

    // Magnitude (with -2048 clamped to 2047), leading-one normalisation,
    // round-half-up on the bit below the significand, and saturation.
    always_comb begin
        if (din_q == 12'h800) begin
            mag = 11'h7FF;
        end else if (din_q[11]) begin
            mag = ~din_q[10:0] + 11'd1;
        end else begin
            mag = din_q[10:0];
        end

        // Small magnitudes (leading one in bits 3..0) are exact with E = 0.
        raw_e = 3'd0;
        raw_f = mag[3:0];
        rnd   = 1'b0;
        // Later iterations overwrite earlier ones, so the highest set bit wins.
        for (int p = 4; p <= 10; p++) begin
            if (mag[p]) begin
                raw_e = 3'(p - 3);
                raw_f = mag[p -: 4];
                rnd   = mag[p-4];
            end
        end

        sum    = {1'b0, raw_f} + {4'd0, rnd};
        conv_s = din_q[11];
        conv_e = raw_e;
        conv_f = sum[3:0];
        if (sum[4]) begin
            if (raw_e == 3'd7) begin
                conv_e = 3'd7;
                conv_f = 4'hF;
            end else begin
                conv_e = raw_e + 3'd1;
                conv_f = 4'h8;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    // Single FSM: capture on grant, register the conversion, then hold the
    // result until the consumer takes it; ptr only advances on that handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt_q     <= '0;
            din_q     <= '0;
            out_valid <= 1'b0;
            out_id    <= '0;
            out_s     <= 1'b0;
            out_e     <= '0;
            out_f     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        din_q <= grant_data;
                        gnt_q <= grant_idx;
                        state <= CONV;
                    end
                end
                CONV: begin
                    out_s     <= conv_s;
                    out_e     <= conv_e;
                    out_f     <= conv_f;
                    out_id    <= gnt_q;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        ptr       <= (gnt_q == ID_W'(N_REQ - 1)) ? '0
                                                                 : gnt_q + ID_W'(1);
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fpcvt_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fpcvt_arb
//  Description : Self-checking bench for fpcvt_arb: directed conversion,
//                fairness, backpressure and reset steps followed by random
//                traffic, all compared against a transaction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fpcvt_arb;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [47:0]  req_data;
    logic [3:0]   req_ready;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_id;
    logic         out_s;
    logic [2:0]   out_e;
    logic [3:0]   out_f;
    logic         busy;

    fpcvt_arb #(.N_REQ(4), .ID_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id),
        .out_s     (out_s),
        .out_e     (out_e),
        .out_f     (out_f),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks;
    int          failures;

    // Requester side: pending flag and held sample per requester.
    logic [3:0]  pend;
    logic [11:0] pdata [4];

    // Model state: round-robin pointer and the single outstanding transaction.
    int          mptr;
    bit          inflight;
    int          gcyc;
    int          cyc;
    int          exp_id;
    logic        exp_s;
    int          exp_e;
    int          exp_f;
    int          grant_log [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference conversion from the arithmetic rules: value ~= F * 2^E with
    // F normalised to 8..15, rounded half-up, saturating at 15 * 2^7.
    task automatic ref_conv(input logic [11:0] d, output logic s, output int e, output int f);
        int v;
        int m;
        v = $signed(d);
        m = (v < 0) ? -v : v;
        if (m > 2047) m = 2047;
        s = d[11];
        if (m < 16) begin
            e = 0;
            f = m;
        end else begin
            e = 1;
            while (m >= (16 << e)) e++;
            f = (m + (1 << (e - 1))) >> e;
            if (f == 16) begin
                if (e == 7) begin
                    f = 15;
                end else begin
                    e = e + 1;
                    f = 8;
                end
            end
        end
    endtask

    task automatic drive();
        req_valid = pend;
        for (int i = 0; i < 4; i++) req_data[i*12 +: 12] = pdata[i];
    endtask

    // One clock cycle: drive, compare every observable output against the
    // model, then advance the model across the coming edge.
    task automatic run_cycle();
        int         g;
        int         c;
        logic [3:0] exp_rr;
        bit         exp_ov;
        drive();
        #1;
        g = -1;
        for (int k = 0; k < 4; k++) begin
            c = (mptr + k) % 4;
            if (g < 0 && pend[c]) g = c;
        end
        exp_rr = (!inflight && g >= 0) ? 4'(1 << g) : 4'd0;
        exp_ov = inflight && (cyc >= gcyc + 2);
        chk("req_ready", req_ready, exp_rr);
        chk("busy", busy, inflight);
        chk("out_valid", out_valid, exp_ov);
        if (exp_ov) begin
            chk("out_id", out_id, exp_id);
            chk("out_s", out_s, exp_s);
            chk("out_e", out_e, exp_e);
            chk("out_f", out_f, exp_f);
            if (out_ready) begin
                inflight = 1'b0;
                mptr     = (exp_id + 1) % 4;
            end
        end
        if (exp_rr != 4'd0) begin
            inflight = 1'b1;
            gcyc     = cyc;
            exp_id   = g;
            ref_conv(pdata[g], exp_s, exp_e, exp_f);
            pend[g]  = 1'b0;
            grant_log.push_back(g);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Reset for one edge with all requesters valid; ready must stay low.
    task automatic do_reset();
        rst_n = 1'b0;
        pend  = 4'hF;
        drive();
        #1;
        chk("rst_req_ready_pre", req_ready, 4'd0);
        @(posedge clk);
        #1;
        cyc++;
        chk("rst_req_ready", req_ready, 4'd0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_id", out_id, 2'd0);
        chk("rst_out_s", out_s, 1'b0);
        chk("rst_out_e", out_e, 3'd0);
        chk("rst_out_f", out_f, 4'd0);
        chk("rst_busy", busy, 1'b0);
        rst_n    = 1'b1;
        mptr     = 0;
        inflight = 1'b0;
    endtask

    task automatic xact(input int r, input logic [11:0] d);
        pend[r]  = 1'b1;
        pdata[r] = d;
        repeat (3) run_cycle();
    endtask

    // Single conversion with the result also compared to hand-derived values.
    task automatic single(input int r, input logic [11:0] d, input logic s, input int e, input int f);
        pend[r]  = 1'b1;
        pdata[r] = d;
        run_cycle();
        run_cycle();
        chk("dir_valid", out_valid, 1'b1);
        chk("dir_id", out_id, r);
        chk("dir_s", out_s, s);
        chk("dir_e", out_e, e);
        chk("dir_f", out_f, f);
        run_cycle();
    endtask

    function automatic logic [11:0] rand_data();
        logic [31:0] r;
        logic [11:0] edges [6];
        edges[0] = 12'h000; edges[1] = 12'h7FF; edges[2] = 12'h800;
        edges[3] = 12'hFFF; edges[4] = 12'h001; edges[5] = 12'h07D;
        r = $urandom();
        if ($urandom_range(0, 4) == 0) return edges[$urandom_range(0, 5)];
        return r[11:0];
    endfunction

    initial begin
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        gcyc      = 0;
        mptr      = 0;
        inflight  = 1'b0;
        exp_id    = 0;
        exp_s     = 1'b0;
        exp_e     = 0;
        exp_f     = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) pdata[i] = 12'h000;
        pend      = 4'h0;
        req_valid = 4'h0;
        req_data  = '0;

        // Reset values.
        do_reset();
        pend = 4'h0;

        // Basic conversion and latency: ready at T, valid at T+2.
        single(0, 12'h07D, 1'b0, 4, 8);

        // Boundary values.
        single(1, 12'h000, 1'b0, 0, 0);
        single(2, 12'h7FF, 1'b0, 7, 15);
        single(3, 12'h800, 1'b1, 7, 15);
        single(0, 12'hFFF, 1'b1, 0, 1);

        // Fairness: all requesters held valid from reset, data 1..4.
        pdata[0] = 12'd1; pdata[1] = 12'd2; pdata[2] = 12'd3; pdata[3] = 12'd4;
        do_reset();
        grant_log.delete();
        repeat (15) begin
            pend = 4'hF;
            run_cycle();
        end
        pend = 4'h0;
        chk("rr_count", grant_log.size(), 5);
        if (grant_log.size() == 5) begin
            chk("rr_order0", grant_log[0], 0);
            chk("rr_order1", grant_log[1], 1);
            chk("rr_order2", grant_log[2], 2);
            chk("rr_order3", grant_log[3], 3);
            chk("rr_order4", grant_log[4], 0);
        end

        // Wrap and skip: after requester 2, requesters 1 and 3 -> 3 then 1.
        xact(2, 12'h123);
        grant_log.delete();
        pend = 4'b1010;
        pdata[1] = 12'hF00;
        pdata[3] = 12'h0F0;
        repeat (6) run_cycle();
        chk("wrap_count", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            chk("wrap_first", grant_log[0], 3);
            chk("wrap_second", grant_log[1], 1);
        end

        // Backpressure: five cycles in HOLD with a competing request pending.
        out_ready = 1'b0;
        pend[1]   = 1'b1;
        pdata[1]  = 12'h5A5;
        run_cycle();
        run_cycle();
        pend[3]   = 1'b1;
        pdata[3]  = 12'hA5A;
        repeat (5) run_cycle();
        chk("bp_valid", out_valid, 1'b1);
        chk("bp_busy", busy, 1'b1);
        out_ready = 1'b1;
        repeat (4) run_cycle();
        chk("bp_done_busy", busy, 1'b0);

        // Reset while in CONV: result discarded, pointer back to 0.
        xact(2, 12'h456);
        pend[1]  = 1'b1;
        pdata[1] = 12'h321;
        run_cycle();
        rst_n = 1'b0;
        pend  = 4'h0;
        drive();
        #1;
        chk("mid_rst_ready", req_ready, 4'd0);
        @(posedge clk);
        #1;
        cyc++;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_e", out_e, 3'd0);
        chk("mid_rst_f", out_f, 4'd0);
        rst_n    = 1'b1;
        mptr     = 0;
        inflight = 1'b0;
        run_cycle();
        chk("mid_rst_idle_valid", out_valid, 1'b0);
        grant_log.delete();
        pend     = 4'b1001;
        pdata[0] = 12'h010;
        pdata[3] = 12'h030;
        repeat (6) run_cycle();
        chk("mid_rst_count", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            chk("mid_rst_first", grant_log[0], 0);
        end

        // Random traffic with occasional withdrawals and backpressure.
        repeat (900) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i]  = 1'b1;
                    pdata[i] = rand_data();
                end else if (pend[i] && $urandom_range(0, 19) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 9) < 7);
            run_cycle();
        end
        pend      = 4'h0;
        out_ready = 1'b1;
        repeat (6) run_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fpcvt_arb.md
# fpcvt_arb

Round-robin arbiter and sequencer that shares one 12-bit-to-floating-point converter (the FPCVT datapath) between `N_REQ` independent requesters. Each requester offers a 12-bit two's-complement sample over a valid/ready handshake. The block grants one requester at a time and registers the sample into the converter input. It then registers the converter's sign/exponent/significand result, tagged with the requester index, onto a single valid/ready output port. It sits between the sample producers and the downstream display/logging consumer.

## Interface
- `N_REQ`, default 4: number of requesters; legal 2..8.
- `ID_W`, default 2: width of requester index; must equal ceil(log2(`N_REQ`)).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `req_valid`  in  `N_REQ`  bit i: requester i offers a sample.
- `req_data`  in  12*`N_REQ`  bits [12i+11:12i] hold requester i's two's-complement sample.
- `req_ready`  out  `N_REQ`  one-hot or zero; bit i: requester i's sample is taken this cycle.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `out_id`  out  `ID_W`  index of the requester that produced the result.
- `out_s`  out  1  sign.
- `out_e`  out  3  exponent.
- `out_f`  out  4  significand; represented value is `out_f` * 2^`out_e`.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, CONV, HOLD.
- IDLE:
  - If no `req_valid` bit is set, stay in IDLE with `req_ready` = 0.
  - Otherwise, grant g is the first set `req_valid` bit, searching upward from pointer `ptr` and wrapping from `N_REQ`-1 to 0.
  - `req_ready[g]` = 1 combinationally in the same cycle. Latch `req_data[g]` into `din_q` and g into `gnt_q`, then go to CONV.
- CONV:
  - `din_q` drives the shared converter.
  - On the clock edge, register the converter's S/E/F into `out_s`/`out_e`/`out_f` and `gnt_q` into `out_id`.
  - Set `out_valid` = 1 and go to HOLD.
- HOLD:
  - `out_valid` = 1. All outputs stay stable until `out_ready` = 1.
  - On the handshake edge: `out_valid` goes to 0, `ptr` becomes (`gnt_q`+1) mod `N_REQ`, and the FSM returns to IDLE.
- `req_ready` is 0 in CONV and HOLD. Requesters hold `req_valid` and `req_data` until they see `req_ready`.
- Deasserting `req_valid` before a grant is legal: the request is simply not granted.
- Conversion rules, implemented by the shared converter:
  - S is the MSB of D. Magnitude is |D|; D = -2048 (12'h800) saturates to magnitude 2047.
  - The leading-zero count z of the 12-bit magnitude sets E = 8 - z for z in 1..7, and E = 0 for z >= 8.
  - F is the 4 bits starting at the leading one, or magnitude[3:0] when E = 0. The 5th bit rounds half-up.
  - If rounding overflows F, then F = 4'b1000 and E is incremented. If E is already 7, saturate to E = 7, F = 15.
- `ptr` update happens only on an output handshake. A requester is never granted twice while another valid requester waits.
- Reset takes effect in any state and discards any captured or pending result.

## Timing
- Reset values:
  - state IDLE, `ptr` 0, `gnt_q` 0, `din_q` 0.
  - `out_valid` 0, `out_id` 0, `out_s` 0, `out_e` 0, `out_f` 0.
  - `busy` 0, `req_ready` 0.
  - During the reset cycle, `req_ready` = 0 regardless of `req_valid`.
- Request handshake at cycle T (`req_valid[g]` & `req_ready[g]`) leads to `out_valid` = 1 from cycle T+2.
- With `out_ready` tied high, the output handshake occurs at T+2 and the next grant can occur at T+3. Peak throughput is one conversion per 3 cycles.
- `out_valid` must not drop, and `out_id`/`out_s`/`out_e`/`out_f` must not change, while `out_valid` = 1 and `out_ready` = 0.
- Output changes to `out_id`, `out_s`, `out_e` and `out_f` occur only on the CONV→HOLD edge or in reset.
- The converter is combinational. `din_q`-to-register is a single-cycle path and no multicycle constraint is applied.

## Test plan
- Conversion values (one requester, `out_ready` high):
  - Reset, then requester 0 sends 12'h07D (125) → `out_s`=0, `out_e`=4, `out_f`=8, `out_id`=0.
  - `req_ready[0]` is seen at T; `out_valid` is seen at T+2.
- Boundaries:
  - 12'h000 → S0 E0 F0.
  - 12'h7FF → S0 E7 F15.
  - 12'h800 → S1 E7 F15.
  - 12'hFFF → S1 E0 F1.
- Round-robin fairness: all four `req_valid` held high from reset with data 1, 2, 3, 4 → grants, and therefore `out_id`, in order 0, 1, 2, 3, 0, with `out_f` = 1, 2, 3, 4.
- Wrap and skip: `ptr`=3 after granting requester 2; requesters 1 and 3 valid → grant 3 first, then 1.
- Backpressure: hold `out_ready` low for 5 cycles in HOLD → `out_valid` and the data stay constant, `req_ready` stays 0, `busy` stays 1. Raising `out_ready` returns the FSM to IDLE on the next edge.
- Reset mid-operation: assert `rst_n`=0 in CONV → next cycle IDLE, `out_valid`=0, `ptr`=0, no result emitted. After release, requester 0 is granted first if valid.
